// File: rtl/punc_control_pkg.sv
// Shared opcode, FSM state, datapath select and ALU function encodings for the PUnC control unit.
package punc_control_pkg;

  localparam logic [3:0] OC_BR   = 4'b0000;
  localparam logic [3:0] OC_ADD  = 4'b0001;
  localparam logic [3:0] OC_LD   = 4'b0010;
  localparam logic [3:0] OC_ST   = 4'b0011;
  localparam logic [3:0] OC_JSR  = 4'b0100;
  localparam logic [3:0] OC_AND  = 4'b0101;
  localparam logic [3:0] OC_LDR  = 4'b0110;
  localparam logic [3:0] OC_STR  = 4'b0111;
  localparam logic [3:0] OC_RTI  = 4'b1000;
  localparam logic [3:0] OC_NOT  = 4'b1001;
  localparam logic [3:0] OC_LDI  = 4'b1010;
  localparam logic [3:0] OC_STI  = 4'b1011;
  localparam logic [3:0] OC_JMP  = 4'b1100;
  localparam logic [3:0] OC_RES  = 4'b1101;
  localparam logic [3:0] OC_LEA  = 4'b1110;
  localparam logic [3:0] OC_TRAP = 4'b1111;

  typedef enum logic [2:0] {
    STATE_FETCH  = 3'd0,
    STATE_DECODE = 3'd1,
    STATE_EXEC   = 3'd2,
    STATE_EXEC2  = 3'd3,
    STATE_HALT   = 3'd4
  } state_t;

  localparam logic [1:0] MEM_W_ADDR_SEL_A       = 2'd1;
  localparam logic [1:0] MEM_W_ADDR_SEL_B       = 2'd2;
  localparam logic [1:0] MEM_W_ADDR_SEL_MEMDATA = 2'd3;

  localparam logic       MEM_W_DATA_SEL_RF      = 1'b1;

  localparam logic [1:0] MEM_R_ADDR_SEL_PC       = 2'd0;
  localparam logic [1:0] MEM_R_ADDR_SEL_A        = 2'd1;
  localparam logic [1:0] MEM_R_ADDR_SEL_B        = 2'd2;
  localparam logic [1:0] MEM_R_ADDR_SEL_INDIRECT = 2'd3;

  localparam logic       RF_R0_ADDR_SEL_A = 1'b1;
  localparam logic       RF_R1_ADDR_SEL_B = 1'b1;

  localparam logic [1:0] RF_W_DATA_SEL_ALU = 2'd0;
  localparam logic [1:0] RF_W_DATA_SEL_MEM = 2'd1;
  localparam logic [1:0] RF_W_DATA_SEL_A   = 2'd2;
  localparam logic [1:0] RF_W_DATA_SEL_PC  = 2'd3;

  localparam logic       RF_W_ADDR_SEL_DR = 1'b0;
  localparam logic       RF_W_ADDR_SEL_R7 = 1'b1;

  localparam logic [1:0] PC_LD_DATA_SEL_A = 2'd1;
  localparam logic [1:0] PC_LD_DATA_SEL_B = 2'd2;
  localparam logic [1:0] PC_LD_DATA_SEL_C = 2'd3;

  localparam logic       COND_LD_DATA_SEL_ALU = 1'b0;
  localparam logic       COND_LD_DATA_SEL_RF  = 1'b1;

  localparam logic [2:0] ALU_FN_PASS  = 3'd0;
  localparam logic [2:0] ALU_FN_ADD   = 3'd1;
  localparam logic [2:0] ALU_FN_AND   = 3'd2;
  localparam logic [2:0] ALU_FN_NOT   = 3'd3;
  localparam logic [2:0] ALU_FN_ADD_I = 3'd4;
  localparam logic [2:0] ALU_FN_AND_I = 3'd5;

  // Operate-class ALU function: immediate form chosen by ir[5].
  function automatic logic [2:0] alu_fn(input logic [3:0] op, input logic imm);
    if (op == OC_NOT)
      return ALU_FN_NOT;
    else if (op == OC_AND)
      return imm ? ALU_FN_AND_I : ALU_FN_AND;
    else
      return imm ? ALU_FN_ADD_I : ALU_FN_ADD;
  endfunction

  function automatic logic br_taken(input logic [2:0] mask, input logic n, input logic z,
                                    input logic p);
    return (mask[2] & n) | (mask[1] & z) | (mask[0] & p);
  endfunction

  function automatic logic is_indirect(input logic [3:0] op);
    return (op == OC_LDI) || (op == OC_STI);
  endfunction

endpackage

// File: rtl/punc_control.sv
// PUnC LC3 control unit: multi-cycle fetch/decode/execute FSM driving the datapath selects and enables.
// Define PUNC_INSTR_COUNT_EN to add the retired-instruction counter output instr_count.
module punc_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  output logic        mem_w_en,
  output logic [1:0]  mem_w_addr_sel,
  output logic        mem_w_data_sel,
  output logic [1:0]  mem_r_addr_sel,
  output logic        rf_w_en,
  output logic        rf_r0_addr_sel,
  output logic        rf_r1_addr_sel,
  output logic [1:0]  rf_w_data_sel,
  output logic        rf_w_addr_sel,
  output logic        ir_ld,
  output logic        pc_ld,
  output logic        pc_clr,
  output logic        pc_inc,
  output logic [1:0]  pc_ld_data_sel,
  output logic [2:0]  alu_sel,
  output logic        cond_ld,
  output logic        cond_ld_data_sel,
  output logic        halted
`ifdef PUNC_INSTR_COUNT_EN
  ,
  output logic [31:0] instr_count
`endif
);
  import punc_control_pkg::*;

  state_t     state;
  state_t     next_state;
  logic [3:0] opcode;

  assign opcode = ir[15:12];

  // Register fields and offsets are consumed by the datapath, not here.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[8:6], ir[4:0]};

  always_ff @(posedge clk) begin
    if (rst)
      state <= STATE_FETCH;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      STATE_FETCH:  next_state = STATE_DECODE;
      STATE_DECODE: next_state = (opcode == OC_TRAP) ? STATE_HALT : STATE_EXEC;
      STATE_EXEC:   next_state = is_indirect(opcode) ? STATE_EXEC2 : STATE_FETCH;
      STATE_EXEC2:  next_state = STATE_FETCH;
      STATE_HALT:   next_state = STATE_HALT;
      default:      next_state = STATE_FETCH;
    endcase
  end

  always_comb begin
    mem_w_en         = 1'b0;
    mem_w_addr_sel   = 2'd0;
    mem_w_data_sel   = 1'b0;
    mem_r_addr_sel   = 2'd0;
    rf_w_en          = 1'b0;
    rf_r0_addr_sel   = 1'b0;
    rf_r1_addr_sel   = 1'b0;
    rf_w_data_sel    = 2'd0;
    rf_w_addr_sel    = 1'b0;
    ir_ld            = 1'b0;
    pc_ld            = 1'b0;
    pc_clr           = 1'b0;
    pc_inc           = 1'b0;
    pc_ld_data_sel   = 2'd0;
    alu_sel          = ALU_FN_PASS;
    cond_ld          = 1'b0;
    cond_ld_data_sel = 1'b0;
    halted           = 1'b0;

    // Reset overrides the state decode so an aborted instruction never commits.
    if (rst) begin
      pc_clr = 1'b1;
    end else begin
      case (state)
        STATE_FETCH: begin
          mem_r_addr_sel = MEM_R_ADDR_SEL_PC;
          ir_ld          = 1'b1;
          pc_inc         = 1'b1;
        end

        STATE_EXEC: begin
          case (opcode)
            OC_ADD, OC_AND, OC_NOT: begin
              rf_r0_addr_sel = RF_R0_ADDR_SEL_A;
              if (!ir[5])
                rf_r1_addr_sel = RF_R1_ADDR_SEL_B;
              alu_sel          = alu_fn(opcode, ir[5]);
              rf_w_data_sel    = RF_W_DATA_SEL_ALU;
              rf_w_en          = 1'b1;
              cond_ld          = 1'b1;
              cond_ld_data_sel = COND_LD_DATA_SEL_ALU;
            end

            OC_LD, OC_LDR, OC_LEA: begin
              rf_w_en          = 1'b1;
              cond_ld          = 1'b1;
              cond_ld_data_sel = COND_LD_DATA_SEL_RF;
              if (opcode == OC_LEA) begin
                rf_w_data_sel = RF_W_DATA_SEL_A;
              end else begin
                rf_w_data_sel  = RF_W_DATA_SEL_MEM;
                mem_r_addr_sel = (opcode == OC_LD) ? MEM_R_ADDR_SEL_A : MEM_R_ADDR_SEL_B;
              end
            end

            OC_ST, OC_STR: begin
              mem_w_en       = 1'b1;
              mem_w_data_sel = MEM_W_DATA_SEL_RF;
              mem_w_addr_sel = (opcode == OC_ST) ? MEM_W_ADDR_SEL_A : MEM_W_ADDR_SEL_B;
            end

            OC_BR: begin
              if (br_taken(ir[11:9], n, z, p)) begin
                pc_ld          = 1'b1;
                pc_ld_data_sel = PC_LD_DATA_SEL_A;
              end
            end

            OC_JMP: begin
              pc_ld          = 1'b1;
              pc_ld_data_sel = PC_LD_DATA_SEL_B;
            end

            OC_JSR: begin
              rf_w_addr_sel  = RF_W_ADDR_SEL_R7;
              rf_w_data_sel  = RF_W_DATA_SEL_PC;
              rf_w_en        = 1'b1;
              pc_ld          = 1'b1;
              pc_ld_data_sel = ir[11] ? PC_LD_DATA_SEL_C : PC_LD_DATA_SEL_B;
            end

            // First half of an indirect access: fetch the pointer word.
            OC_LDI, OC_STI: begin
              mem_r_addr_sel = MEM_R_ADDR_SEL_A;
            end

            default: begin
            end
          endcase
        end

        STATE_EXEC2: begin
          if (opcode == OC_LDI) begin
            mem_r_addr_sel   = MEM_R_ADDR_SEL_INDIRECT;
            rf_w_data_sel    = RF_W_DATA_SEL_MEM;
            rf_w_en          = 1'b1;
            cond_ld          = 1'b1;
            cond_ld_data_sel = COND_LD_DATA_SEL_RF;
          end else if (opcode == OC_STI) begin
            mem_r_addr_sel = MEM_R_ADDR_SEL_A;
            mem_w_addr_sel = MEM_W_ADDR_SEL_MEMDATA;
            mem_w_en       = 1'b1;
          end
        end

        STATE_HALT: begin
          halted = 1'b1;
        end

        default: begin
        end
      endcase
    end
  end

`ifdef PUNC_INSTR_COUNT_EN
  logic retire;
  assign retire = ((state == STATE_EXEC) || (state == STATE_EXEC2)) &&
                  (next_state == STATE_FETCH);

  always_ff @(posedge clk) begin
    if (rst)
      instr_count <= '0;
    else if (retire)
      instr_count <= instr_count + 32'd1;
  end
`endif

endmodule
